// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
//   Shares the single HPS sector channel between two disk drives. Sector
//   transactions are serialised with round-robin priority. Buffer strobes and
//   write data are steered to and from the granted drive. A request the HPS
//   never acknowledges is aborted after TIMEOUT cycles.
//
// Ports
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   dev_rd/dev_wr [1:0]       per-drive read/write requests (held until dev_ack)
//   dev_lba0/dev_lba1 [31:0]  per-drive sector address
//   dev_din0/dev_din1 [7:0]   per-drive write data
//   dev_ack [1:0]             per-drive acknowledge (combinational)
//   dev_err [1:0]             per-drive one-cycle timeout pulse
//   dev_buff_wr [1:0]         per-drive read-data strobe (combinational)
//   sd_lba [31:0]             latched LBA of the granted transaction
//   sd_rd/sd_wr [1:0]         request to hps_io, bit = granted drive
//   sd_ack, sd_buff_wr        from hps_io
//   sd_buff_din [7:0]         write data of the granted drive to hps_io
//   busy, grant               arbiter status
module sd_sector_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd16_000_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  dev_rd,
  input  logic [1:0]  dev_wr,
  input  logic [31:0] dev_lba0,
  input  logic [31:0] dev_lba1,
  input  logic [7:0]  dev_din0,
  input  logic [7:0]  dev_din1,
  output logic [1:0]  dev_ack,
  output logic [1:0]  dev_err,
  output logic [1:0]  dev_buff_wr,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        op_wr_q, op_wr_d;
  logic        ack_low_q, ack_low_d;
  logic        busy_q, busy_d;
  logic [31:0] lba_q, lba_d;
  logic [1:0]  sd_rd_q, sd_rd_d;
  logic [1:0]  sd_wr_q, sd_wr_d;
  logic [1:0]  dev_err_q, dev_err_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  pend_s;
  logic        sel_s;
  logic [1:0]  gmask_s;

  assign pend_s  = dev_rd | dev_wr;
  assign gmask_s = grant_q ? 2'b10 : 2'b01;

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      op_wr_q   <= 1'b0;
      ack_low_q <= 1'b0;
      busy_q    <= 1'b0;
      lba_q     <= 32'd0;
      sd_rd_q   <= 2'b00;
      sd_wr_q   <= 2'b00;
      dev_err_q <= 2'b00;
      cnt_q     <= 24'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      op_wr_q   <= op_wr_d;
      ack_low_q <= ack_low_d;
      busy_q    <= busy_d;
      lba_q     <= lba_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      dev_err_q <= dev_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: arbitration, request handshake, timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    op_wr_d   = op_wr_q;
    ack_low_d = ack_low_q;
    lba_d     = lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    dev_err_d = 2'b00;
    cnt_d     = cnt_q;
    sel_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        sd_rd_d = 2'b00;
        sd_wr_d = 2'b00;
        // Both pending: the drive not served last goes first.
        sel_s = (pend_s == 2'b11) ? ~last_q : pend_s[1];
        if (pend_s != 2'b00) begin
          grant_d   = sel_s;
          lba_d     = sel_s ? dev_lba1 : dev_lba0;
          op_wr_d   = ~dev_rd[sel_s];
          cnt_d     = 24'd0;
          ack_low_d = 1'b0;
          state_d   = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack still high from a previous transaction must be seen low
        // before a rising ack is accepted.
        if (!sd_ack) begin
          ack_low_d = 1'b1;
        end else begin
          ack_low_d = ack_low_q;
        end
        if (sd_ack && ack_low_q) begin
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
          state_d = S_XFER;
        end else if (cnt_q == (TIMEOUT - 24'd1)) begin
          sd_rd_d   = 2'b00;
          sd_wr_d   = 2'b00;
          dev_err_d = gmask_s;
          last_d    = grant_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 24'd1;
          sd_rd_d = op_wr_q ? 2'b00 : gmask_s;
          sd_wr_d = op_wr_q ? gmask_s : 2'b00;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          state_d = S_DONE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Zero-latency steering of ack and buffer strobes to the granted drive.
  always_comb begin
    dev_ack     = 2'b00;
    dev_buff_wr = 2'b00;
    if (sd_ack && busy_q && ((state_q != S_REQ) || ack_low_q)) begin
      dev_ack = gmask_s;
    end else begin
      dev_ack = 2'b00;
    end
    if (sd_buff_wr && busy_q) begin
      dev_buff_wr = gmask_s;
    end else begin
      dev_buff_wr = 2'b00;
    end
  end

  assign sd_buff_din = grant_q ? dev_din1 : dev_din0;
  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign dev_err     = dev_err_q;
  assign busy        = busy_q;
  assign grant       = grant_q;

endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Shares the single HPS sector channel (one `sd_lba` bus, per-drive `sd_rd`/`sd_wr` bits, one `sd_ack`, one sector buffer port) between two disk-drive requesters, so Disk 0 and Disk 1 can both be mounted behind the FDC.
- Sits between the `tatung` disk logic and `hps_io`.
- Serialises sector transactions with round-robin priority.
- Steers buffer strobes and write data to and from the granted drive.
- Aborts transactions the HPS never acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 24'd16_000_000: `clk_sys` cycles to wait for `sd_ack` before aborting (0.5 s at 32 MHz).

Ports:
- `clk_sys`  in  1  system clock (32 MHz); all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dev_rd`  in  2  per-drive sector read request; held high until that drive's `dev_ack` bit rises.
- `dev_wr`  in  2  per-drive sector write request; same convention as `dev_rd`.
- `dev_lba0`, `dev_lba1`  in  32 each  sector address for drive 0 / drive 1; stable while the request is high.
- `dev_din0`, `dev_din1`  in  8 each  write data for drive 0 / drive 1, indexed by `sd_buff_addr`.
- `dev_ack`  out  2  per-drive acknowledge.
- `dev_err`  out  2  one-cycle timeout-abort pulse per drive.
- `dev_buff_wr`  out  2  per-drive read-data strobe. `sd_buff_addr` and `sd_buff_dout` fan out to both drives outside this block.
- `sd_lba`  out  32  latched LBA of the granted transaction.
- `sd_rd`  out  2  to `hps_io`; bit index equals the granted drive.
- `sd_wr`  out  2  to `hps_io`; bit index equals the granted drive.
- `sd_ack`  in  1  from `hps_io`.
- `sd_buff_wr`  in  1  from `hps_io`.
- `sd_buff_din`  out  8  to `hps_io`; write data from the granted drive.
- `busy`  out  1  high in any state except IDLE.
- `grant`  out  1  index of the granted drive (last grant while IDLE).

## Operation
- **Reset values** (all registered outputs): `sd_rd=0`, `sd_wr=0`, `sd_lba=0`, `dev_err=0`, `busy=0`, `grant=0`, `last=1`, timeout counter 0, state IDLE. Reset may assert mid-transaction and forces IDLE immediately.
- **Pending per drive:** `pend[i] = dev_rd[i] | dev_wr[i]`.
- **IDLE:**
  - If only one drive is pending, grant it.
  - If both are pending, grant `~last`.
  - On grant: latch the drive's LBA into `sd_lba`; latch `op = rd` if `dev_rd[i]`, else `wr` (read wins when both bits are high); clear the counter; clear `ack_low_seen`; go to REQ.
- **REQ:**
  - Drive `sd_rd[grant]` or `sd_wr[grant]` according to `op`; the other three bits stay 0.
  - Set `ack_low_seen` once `sd_ack` is sampled 0.
  - When `sd_ack==1` and `ack_low_seen`: clear `sd_rd`/`sd_wr`, go to XFER. A stale high ack on entry is therefore ignored.
  - Otherwise increment the counter. When it reaches `TIMEOUT-1`: clear `sd_rd`/`sd_wr`, pulse `dev_err[grant]` for one cycle, set `last=grant`, go to IDLE.
- **XFER:**
  - Wait for `sd_ack==0`, then go to DONE. No timeout applies in XFER.
- **DONE:**
  - One cycle. Set `last=grant`, go to IDLE.
- **Combinational steering:**
  - `dev_ack[i] = sd_ack & busy & (grant==i) & (state!=REQ | ack_low_seen)`.
  - `dev_buff_wr[i] = sd_buff_wr & busy & (grant==i)`.
  - `sd_buff_din = grant ? dev_din1 : dev_din0`.
- **Request withdrawal:** a drive dropping its request in REQ before ack does not cancel the transaction. It completes or times out normally.
- **Non-granted drive:** its requests stay pending and are never seen by `hps_io` until it is granted.

## Timing
- Request sampled high at edge N in IDLE → `sd_rd`/`sd_wr` and `sd_lba` valid after edge N+1.
- `sd_ack` rising sampled at edge M in REQ → `sd_rd`/`sd_wr` low after edge M+1. `dev_ack` follows `sd_ack` combinationally in the same cycle.
- Buffer strobes and write data: zero-cycle path. `sd_buff_din` follows `sd_buff_addr` through the mux only.
- `sd_ack` falling sampled at edge K → DONE at K+1 → IDLE at K+2. Earliest next grant is K+2; its request is visible at K+3.
- Timeout: `dev_err` pulses exactly `TIMEOUT` cycles after REQ entry; `busy` low the following cycle.
- Back-to-back: with both drives continuously pending, grants strictly alternate 0,1,0,1.

## Test plan
- **Single read, drive 0:** `dev_rd=01`, `dev_lba0=0x12` → `sd_rd=01` and `sd_lba=0x12` one cycle later. Ack 512 cycles with `sd_buff_wr` strobes → 512 `dev_buff_wr[0]` pulses and 0 on `dev_buff_wr[1]`; `busy` low 2 cycles after ack falls.
- **Simultaneous requests:** `dev_rd=11` from reset (`last=1`) → drive 0 served first, then drive 1 without any idle request gap; `sd_lba` shows `dev_lba0` then `dev_lba1`.
- **Write steering:** `dev_wr[1]`, `dev_din1=0xA5`, `dev_din0=0x00` → `sd_wr=10` and `sd_buff_din=0xA5` throughout XFER.
- **Stale ack:** `sd_ack` held high when REQ is entered → no transition and `dev_ack` stays 0 until ack goes 0 then 1.
- **Timeout:** `TIMEOUT=100`, no ack → `dev_err[0]` pulses one cycle at cycle 100 after REQ entry, `sd_rd=00`; a still-high `dev_rd` re-grants afterwards.
- **Reset mid-XFER:** `reset_n` low during XFER → all outputs at reset values asynchronously; a fresh request after release is served normally.
